uart_wb_master: RTL and testbench
=================================

UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUS-state cycles to wait for wbm_ack_i.
REQ-003 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO can accept.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  32  target address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte enables.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_dat  out  32  read data, or 0.
- rsp_err  out  1  timeout flag.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte select.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.
- busy  out  1  high in any state other than IDLE, or when the FIFO is non-empty.

Function
REQ-004 SHALL store accepted commands {we, adr, dat, sel} in a DEPTH-entry FIFO; a push occurs on an edge where cmd_valid and cmd_ready are both high.
REQ-005 SHALL drive cmd_ready = not FIFO full, combinationally from the registered count; there is no push while full, even if a pop happens in the same cycle.
REQ-006 SHALL implement FSM states IDLE, BUS and RESP.
REQ-007 IDLE: if the FIFO is non-empty, on the next edge SHALL pop one entry, register it onto wbm_we_o/adr_o/dat_o/sel_o, assert wbm_cyc_o and wbm_stb_o, clear the timeout counter, and go to BUS; otherwise SHALL stay in IDLE.
REQ-008 BUS: SHALL hold cyc, stb and all wbm_* outputs stable until termination.
REQ-009 BUS, wbm_ack_i high at an edge: SHALL deassert cyc/stb on that edge, capture rsp_dat = wbm_dat_i for reads (0 for writes), set rsp_err=0, set rsp_valid=1, and go to RESP.
REQ-010 BUS, no ack: SHALL increment the timeout counter by 1 (width clog2(TIMEOUT+1)).
REQ-011 BUS timeout: on the edge where the counter equals TIMEOUT-1 and ack is low, SHALL deassert cyc/stb, set rsp_dat=0, rsp_err=1, rsp_valid=1, and go to RESP; the bus therefore stays asserted exactly TIMEOUT cycles. Ack arriving on that same edge SHALL take priority (normal completion).
REQ-012 RESP: SHALL hold rsp_valid, rsp_dat and rsp_err stable until an edge with rsp_ready high, then clear rsp_valid and go to IDLE; no new bus cycle starts before that edge.
REQ-013 wbm_ack_i SHALL be ignored outside BUS.
REQ-014 Latency: command pushed at edge N into an empty FIFO in IDLE -> cyc/stb high after edge N+1; ack high before edge N+2 -> rsp_valid high after edge N+2. Minimum spacing between consecutive bus cycles is 3 edges with rsp_ready tied high.
REQ-015 Pushes SHALL continue to be accepted during BUS and RESP while the FIFO is not full; commands SHALL be issued strictly in FIFO order.
REQ-016 wbm_stb_o SHALL equal wbm_cyc_o at all times (single transfers only, no bursts).

Reset
REQ-017 rst_n low SHALL immediately clear the following, regardless of state: FSM=IDLE, FIFO empty, cyc/stb/we=0, sel=0, adr=0, dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, timeout counter=0.
REQ-018 Reset asserted mid-BUS SHALL abort the transfer with no response generated; after deassertion, cmd_ready=1 on the first cycle.

Verification
REQ-019 Write {adr=0x3000_0008, dat=0x0000_0041, sel=0xF}; slave acks 2 cycles after stb -> wbm_* show those values; rsp_valid=1, rsp_err=0, rsp_dat=0.
REQ-020 Read adr=0x3000_0000; slave returns 0x0000_005A with ack -> rsp_dat=0x0000_005A, rsp_err=0; cyc low the cycle after ack.
REQ-021 Push 5 commands back-to-back with DEPTH=4, slave not acking, rsp_ready=0 -> cmd_ready low after the 5th push (1 in BUS + 4 queued); the remaining commands complete in order once the slave acks.
REQ-022 Read to an unmapped address, ack never asserted, TIMEOUT=255 -> cyc high exactly 255 cycles, then rsp_err=1, rsp_dat=0.
REQ-023 Ack on the final timeout edge -> rsp_err=0 and rsp_dat=wbm_dat_i.
REQ-024 rst_n pulsed low while in BUS with 2 commands queued -> cyc, stb and rsp_valid drop immediately; the FIFO is empty; no response is produced after reset.

Source files
------------

// File: rtl/uart_wb_master.sv
// Command-FIFO driven Wishbone single-transfer master.
// Commands {we, adr, dat, sel} are queued in a DEPTH-entry FIFO and issued one at a
// time as Wishbone classic cycles. Each cycle ends with a response: the ack'd read
// data or zero for writes, or an error flag when no ack arrives within TIMEOUT cycles.
module uart_wb_master #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] CountFull = CW'(DEPTH);
    // Counter value seen on the last BUS edge before giving up.
    localparam logic [TW-1:0] ToLast    = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    cmd_t          head;

    state_e        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Full test uses the registered count only, so a same-cycle pop never frees a slot.
    assign cmd_ready = (count_q != CountFull);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Transfer sequencing: issue the FIFO head, wait for ack or timeout, hold the response.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        to_cnt_d    = to_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    we_d     = head.we;
                    adr_d    = head.adr;
                    dat_d    = head.dat;
                    sel_d    = head.sel;
                    cyc_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StBus;
                end
            end
            StBus: begin
                // Ack wins over a timeout landing on the same edge.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (to_cnt_q == ToLast) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state and registered bus/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // Single transfers only: strobe is the cycle signal itself.
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_wb_master;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 255;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy;

    int errors = 0;
    int checks = 0;

    uart_wb_master #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    cmd_t        mq[$];     // accepted, not yet issued
    cmd_t        m_cur;     // command currently/last on the bus
    bit          m_bus;     // a transfer is outstanding on the bus
    bit          m_rsp;     // a response is waiting to be consumed
    int          m_age;     // bus cycles elapsed without ack
    logic [31:0] m_rdat;
    logic        m_rerr;

    task automatic model_reset();
        mq.delete();
        m_cur  = '0;
        m_bus  = 1'b0;
        m_rsp  = 1'b0;
        m_age  = 0;
        m_rdat = '0;
        m_rerr = 1'b0;
    endtask

    task automatic model_step();
        bit   take;
        cmd_t inc;
        take = cmd_valid && (mq.size() < DEPTH);
        inc  = {cmd_we, cmd_adr, cmd_dat, cmd_sel};
        if (m_bus) begin
            if (wbm_ack_i) begin
                m_bus  = 1'b0;
                m_rsp  = 1'b1;
                m_rdat = m_cur.we ? 32'h0 : wbm_dat_i;
                m_rerr = 1'b0;
            end else if (m_age == TIMEOUT - 1) begin
                m_bus  = 1'b0;
                m_rsp  = 1'b1;
                m_rdat = 32'h0;
                m_rerr = 1'b1;
            end else begin
                m_age = m_age + 1;
            end
        end else if (m_rsp) begin
            if (rsp_ready) m_rsp = 1'b0;
        end else if (mq.size() > 0) begin
            m_cur = mq.pop_front();
            m_bus = 1'b1;
            m_age = 0;
        end
        if (take) mq.push_back(inc);
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic compare();
        bit show_bus, show_rsp;
        show_bus = m_bus || !rst_n;
        show_rsp = m_rsp || !rst_n;
        check("cmd_ready", {31'h0, cmd_ready}, {31'h0, mq.size() < DEPTH});
        check("busy", {31'h0, busy}, {31'h0, m_bus || m_rsp || (mq.size() > 0)});
        check("cyc", {31'h0, wbm_cyc_o}, {31'h0, m_bus});
        check("stb", {31'h0, wbm_stb_o}, {31'h0, m_bus});
        check("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_rsp});
        if (show_bus) begin
            check("wbm_we", {31'h0, wbm_we_o}, {31'h0, m_cur.we});
            check("wbm_adr", wbm_adr_o, m_cur.adr);
            check("wbm_dat", wbm_dat_o, m_cur.dat);
            check("wbm_sel", {28'h0, wbm_sel_o}, {28'h0, m_cur.sel});
        end
        if (show_rsp) begin
            check("rsp_dat", rsp_dat, m_rdat);
            check("rsp_err", {31'h0, rsp_err}, {31'h0, m_rerr});
        end
    endtask

    always @(negedge clk) compare();

    // ---------------- stimulus helpers (entered/left at a falling edge) ----------------
    task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        int n;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        while (mq.size() >= DEPTH && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) bound_fail("push_wait");
        @(negedge clk);
    endtask

    task automatic wait_stb();
        int n;
        n = 0;
        while (!wbm_stb_o && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!wbm_stb_o) bound_fail("wait_stb");
    endtask

    task automatic ack_once(input logic [31:0] d);
        wbm_dat_i = d;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Safety net in case the DUT locks up a directed wait chain.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, acked two cycles after strobe rises.
        push_cmd(1'b1, 32'h3000_0008, 32'h0000_0041, 4'hF);
        cmd_valid = 1'b0;
        wait_stb();
        check("wr_adr", wbm_adr_o, 32'h3000_0008);
        check("wr_dat", wbm_dat_o, 32'h0000_0041);
        check("wr_sel", {28'h0, wbm_sel_o}, 32'hF);
        check("wr_we", {31'h0, wbm_we_o}, 32'h1);
        @(negedge clk);
        ack_once(32'hFFFF_FFFF);
        check("wr_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("wr_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("wr_rsp_dat", rsp_dat, 32'h0);
        release_rsp();

        // Read, data returned with ack.
        push_cmd(1'b0, 32'h3000_0000, 32'h1111_2222, 4'hF);
        cmd_valid = 1'b0;
        wait_stb();
        ack_once(32'h0000_005A);
        check("rd_rsp_dat", rsp_dat, 32'h0000_005A);
        check("rd_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rd_cyc_after_ack", {31'h0, wbm_cyc_o}, 32'h0);
        release_rsp();

        // Five back-to-back pushes fill bus + FIFO; then drain in order.
        for (int i = 0; i < 5; i++) begin
            push_cmd(i[0], 32'h4000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1));
        end
        check("full_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_stb();
            check("fifo_order_adr", wbm_adr_o, 32'h4000_0000 + 32'(i * 4));
            ack_once($urandom);
            release_rsp();
        end

        // Timeout: no ack, bus must stay up exactly TIMEOUT cycles.
        push_cmd(1'b0, 32'hDEAD_0000, 32'h0, 4'hF);
        cmd_valid = 1'b0;
        wait_stb();
        cnt = 0;
        while (wbm_cyc_o && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_cycles", 32'(cnt), 32'd255);
        check("timeout_err", {31'h0, rsp_err}, 32'h1);
        check("timeout_dat", rsp_dat, 32'h0);
        release_rsp();

        // Ack on the very edge the timeout would fire: normal completion wins.
        push_cmd(1'b0, 32'hDEAD_0004, 32'h0, 4'hF);
        cmd_valid = 1'b0;
        wait_stb();
        repeat (254) @(negedge clk);
        ack_once(32'h1234_ABCD);
        check("late_ack_err", {31'h0, rsp_err}, 32'h0);
        check("late_ack_dat", rsp_dat, 32'h1234_ABCD);
        release_rsp();

        // Reset mid-bus with two commands queued.
        for (int i = 0; i < 3; i++) begin
            push_cmd(1'b1, 32'h5000_0000 + 32'(i), 32'(i), 4'h3);
        end
        cmd_valid = 1'b0;
        check("pre_reset_cyc", {31'h0, wbm_cyc_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check("rst_stb", {31'h0, wbm_stb_o}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", {31'h0, busy}, 32'h0);

        // Randomized traffic; ack toggles freely, including outside bus cycles.
        for (int i = 0; i < 4000; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_adr   = $urandom;
            cmd_dat   = $urandom;
            cmd_sel   = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            wbm_ack_i = ($urandom_range(0, 2) == 0);
            wbm_dat_i = $urandom;
            @(negedge clk);
        end

        // Drain.
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wbm_ack_i = 1'b1;
        repeat (40) @(negedge clk);
        check("drain_busy", {31'h0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
